// File: rtl/nibble_serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_pkg
// Shared definitions for the nibble-serial adder and its 4-bit slice.
//   state_t : control FSM states (IDLE, RUN, DONE)
//   NIB_W   : width of one adder slice in bits
// -----------------------------------------------------------------------------
package nibble_serial_adder_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_slice.sv
// -----------------------------------------------------------------------------
// nibble_slice_add
// Combinational 4-bit ripple adder slice.
// Ports:
//   a, b : 4-bit operand nibbles
//   ci   : carry into bit 0
//   s    : 4-bit sum nibble
//   co   : carry out of bit 3
//   c3   : carry into bit 3 (XOR with co gives signed overflow)
// -----------------------------------------------------------------------------
module nibble_slice_add
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             ci,
    output logic [NIB_W-1:0] s,
    output logic             co,
    output logic             c3
);

    // The low three bits are added as a 4-bit quantity so that bit 3 of the
    // partial sum is exactly the carry into the top bit.
    logic [3:0] lo_sum;

    always_comb begin
        lo_sum = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, ci};
        c3     = lo_sum[3];
        s      = {a[3] ^ b[3] ^ lo_sum[3], lo_sum[2:0]};
        co     = (a[3] & b[3]) | (lo_sum[3] & (a[3] ^ b[3]));
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
// Sequential WIDTH-bit adder that feeds one 4-bit slice a nibble per clock,
// least significant nibble first, with a registered carry between nibbles.
//
// Handshakes (valid/ready): a transfer happens on a rising edge where both
// valid and ready are high. in_ready is high only in IDLE; out_valid is high
// only in DONE and stays high, with y/cout/ovf frozen, until out_ready is seen.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : operand handshake; a, b, cin sampled on accept
//   out_valid/out_ready : result handshake
//   y, cout, ovf      : registered sum, carry out of MSB, signed overflow
//   busy              : high while nibbles are being summed (RUN)
//   state_o           : current FSM state for observation
// -----------------------------------------------------------------------------
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic [1:0]       state_o
);

    localparam int NIBBLES = WIDTH / NIB_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WIDTH-1:0]   y_q;
    logic               cout_q;
    logic               ovf_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    // Bit offset of the current nibble: idx * 4.
    logic [IDX_W+1:0]   bit_off;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [NIB_W-1:0]   sl_s;
    logic               sl_co;
    logic               sl_c3;

    assign bit_off = {idx_q, 2'b00};
    assign a_sh    = a_q >> bit_off;
    assign b_sh    = b_q >> bit_off;

    nibble_slice_add u_slice (
        .a  (a_sh[NIB_W-1:0]),
        .b  (b_sh[NIB_W-1:0]),
        .ci (carry_q),
        .s  (sl_s),
        .co (sl_co),
        .c3 (sl_c3)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            y_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= cin;
                        idx_q      <= '0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    y_q[bit_off +: NIB_W] <= sl_s;
                    carry_q               <= sl_co;
                    if (idx_q == LAST_IDX) begin
                        // Final nibble: latch flags and hold idx in range.
                        cout_q      <= sl_co;
                        ovf_q       <= sl_c3 ^ sl_co;
                        idx_q       <= '0;
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    // Returning to IDLE here means in_ready only rises after
                    // this edge, so a result is never retired and a new
                    // operand accepted on the same edge.
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign y         = y_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed corner cases plus randomized
// transactions, each checked against an arithmetic reference model.
module tb_nibble_serial_adder;
  import nibble_serial_adder_pkg::*;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;
  localparam int TMO     = 50;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic [1:0]       state_o;

  int total = 0;
  int bad   = 0;

  // scoreboard: expected {ovf, cout, y} per transaction
  logic [WIDTH+1:0] exp_q[$];

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy),
    .state_o   (state_o)
  );

  // ---------------- reference model ----------------
  // Plain integer addition; signed overflow when both operands share a sign
  // and the truncated sum has the other sign.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ma,
                                             input logic [WIDTH-1:0] mb,
                                             input logic mc);
    logic [WIDTH:0] full;
    logic           v;
    full = {1'b0, ma} + {1'b0, mb} + {{WIDTH{1'b0}}, mc};
    v = (ma[WIDTH-1] == mb[WIDTH-1]) && (full[WIDTH-1] != ma[WIDTH-1]);
    return {v, full};
  endfunction

  // ---------------- driver / checker for one transaction ----------------
  task automatic run_txn(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                         input logic tc, input int stall, input string name);
    int cyc;
    logic [WIDTH+1:0] exp;
    logic [WIDTH-1:0] y_hold;
    logic             c_hold;
    cyc = 0;
    while (!in_ready && cyc < TMO) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL %s ready_timeout: in_ready=%0b required 1", name, in_ready);
      return;
    end
    exp_q.push_back(model(ta, tb, tc));
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom);
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s run_flags: busy=%0b in_ready=%0b required 1/0", name, busy, in_ready);
    end
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < TMO) begin
      @(negedge clk);
      cyc++;
    end
    exp = exp_q.pop_front();
    total++;
    if (cyc !== NIBBLES) begin
      bad++;
      $display("FAIL %s latency: got %0d cycles required %0d", name, cyc, NIBBLES);
    end
    if (out_valid !== 1'b1) return;
    total++;
    if (y !== exp[WIDTH-1:0]) begin
      bad++;
      $display("FAIL %s y: got %h required %h", name, y, exp[WIDTH-1:0]);
    end
    total++;
    if (cout !== exp[WIDTH]) begin
      bad++;
      $display("FAIL %s cout: got %0b required %0b", name, cout, exp[WIDTH]);
    end
    total++;
    if (ovf !== exp[WIDTH+1]) begin
      bad++;
      $display("FAIL %s ovf: got %0b required %0b", name, ovf, exp[WIDTH+1]);
    end
    // backpressure: new operands offered, result must stay frozen
    y_hold = y; c_hold = cout;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'($urandom);
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || y !== y_hold || cout !== c_hold) begin
        bad++;
        $display("FAIL %s hold: out_valid=%0b in_ready=%0b y=%h cout=%0b required 1/0/%h/%0b",
                 name, out_valid, in_ready, y, cout, y_hold, c_hold);
      end
    end
    // handshake edge with in_valid still high: must not be accepted
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || state_o !== IDLE) begin
      bad++;
      $display("FAIL %s retire: out_valid=%0b in_ready=%0b state=%0d required 0/1/%0d",
               name, out_valid, in_ready, state_o, IDLE);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        y !== '0 || cout !== 1'b0 || ovf !== 1'b0 || state_o !== IDLE) begin
      bad++;
      $display("FAIL reset_values: rdy=%0b vld=%0b busy=%0b y=%h cout=%0b ovf=%0b st=%0d",
               in_ready, out_valid, busy, y, cout, ovf, state_o);
    end
    // leave a result in DONE, then reset asynchronously mid-cycle
    a = 16'hFFFF; b = 16'h0001; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (NIBBLES + 1) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        y !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: rdy=%0b vld=%0b busy=%0b y=%h cout=%0b ovf=%0b required 1/0/0/0/0/0",
               in_ready, out_valid, busy, y, cout, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_txn(16'h1234, 16'h4321, 1'b0, 0, "basic");
  endtask

  task automatic test_carry_chain();
    run_txn(16'hFFFF, 16'h0001, 1'b0, 0, "carry_ripple");
    run_txn(16'hFFFF, 16'hFFFF, 1'b1, 0, "carry_all_ones");
  endtask

  task automatic test_overflow();
    run_txn(16'h7FFF, 16'h0001, 1'b0, 0, "ovf_pos");
    run_txn(16'h8000, 16'h8000, 1'b0, 0, "ovf_neg");
  endtask

  task automatic test_backpressure();
    run_txn(16'h00FF, 16'h0F01, 1'b1, 5, "backpressure");
    run_txn(16'h1111, 16'h2222, 1'b0, 0, "after_backpressure");
  endtask

  task automatic test_reset_in_run();
    int seen;
    a = 16'hABCD; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if (state_o !== IDLE || out_valid !== 1'b0 || busy !== 1'b0 || y !== '0) begin
      bad++;
      $display("FAIL reset_in_run: st=%0d vld=%0b busy=%0b y=%h required %0d/0/0/0",
               state_o, out_valid, busy, y, IDLE);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (NIBBLES + 2) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL reset_no_result: out_valid seen %0d cycles required 0", seen);
    end
    run_txn(16'h0F0F, 16'h00F1, 1'b0, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      run_txn(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
              int'($urandom_range(0, 3)), "random");
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      run_txn(WIDTH'($urandom_range(16'hF000, 16'hFFFF)), WIDTH'($urandom_range(0, 16'h0FFF)),
              1'($urandom), 0, "back_to_back");
    end
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    test_reset();
    test_basic();
    test_carry_chain();
    test_overflow();
    test_backpressure();
    test_reset_in_run();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // watchdog: the whole run is far below this bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
